sync_debounce: RTL
==================

Name: sync_debounce

Overview:
Glitch filter and edge detector for a single-bit level that has already been brought into the local clock domain by the two-flop synchronizer. Consumes the synchronizer's output (din) and produces a stable filtered level plus one-cycle rise/fall strobes. Used on buttons, GPIO inputs and slow status lines before any control logic samples them. Sampling can be prescaled by an external tick so long debounce windows do not need wide counters.

Parameters:
CYCLES, 4, consecutive qualifying samples din must differ from dout before dout changes; legal range 1..65535
RESET_LEVEL, 1'b0, value of dout after reset

Ports:
clk  input  1  sole clock; all logic on posedge
reset  input  1  synchronous, active-high reset
tick  input  1  sample enable; a sample qualifies only in cycles where tick=1 (tie high for per-clock sampling)
din  input  1  synchronized input level (already in clk domain; no further synchronization in this block)
dout  output  1  debounced level
rise  output  1  one-cycle strobe, asserted in the cycle dout goes 0->1
fall  output  1  one-cycle strobe, asserted in the cycle dout goes 1->0

Behaviour:
- Internal counter cnt, width $clog2(CYCLES+1), unsigned; never wraps.
- Reset (reset=1 at posedge): dout<=RESET_LEVEL, cnt<=0, rise<=0, fall<=0. Reset overrides all other inputs; reset mid-count discards progress.
- Each posedge, when not in reset:
  - din==dout: cnt<=0 (regardless of tick). No output change.
  - din!=dout, tick=0: cnt holds.
  - din!=dout, tick=1, cnt<CYCLES-1: cnt<=cnt+1.
  - din!=dout, tick=1, cnt==CYCLES-1: dout<=din, cnt<=0, rise<=din, fall<=~din.
- rise/fall default to 0 every cycle not covered above; never both 1; never asserted in consecutive cycles.
- Any cycle with din==dout (a glitch back) restarts the window; qualifying samples must be consecutive in the sense of no intervening din==dout cycle (tick=0 cycles pause, do not restart).
- Latency with tick tied high: din changes before edge n and stays stable; dout, and the rise/fall strobe, update at edge n+CYCLES-1 (visible after it). CYCLES=1: one-cycle registered pass-through with edge strobes.
- Strobes are registered and coincide exactly with the first cycle of the new dout value.
- No combinational path from any input to any output.

Test Plan:
- Reset: CYCLES=4, RESET_LEVEL=1, assert reset 3 cycles with din=0, tick=1 -> dout=1, rise=fall=0 throughout and in first cycle after release.
- Clean edge: CYCLES=4, tick=1, din 0->1 before edge 10, held -> dout=1 and rise=1 after edge 13 only; rise=0 after edge 14; fall never asserted.
- Glitch rejection: din=1 for 3 cycles then 0 for 1 cycle, repeat 10x -> dout stays 0, no strobes.
- Tick prescale: CYCLES=4, tick high every 3rd cycle, din held at 1 -> dout changes on the 4th tick edge (about 12 cycles), cnt holds between ticks; one-cycle din=0 between ticks restarts the count.
- Falling edge and reset mid-count: dout=1, din->0 for 2 ticks, reset pulse, din still 0 -> after reset dout=RESET_LEVEL(0), no fall strobe; repeat with RESET_LEVEL=1 -> full CYCLES new samples required before fall=1 for exactly one cycle.
- CYCLES=1: toggle din every 2 cycles -> dout follows with one cycle delay, rise/fall alternate each change.

Source files
------------

// File: rtl/sync_debounce.sv
// sync_debounce: glitch filter with registered rise/fall strobes for a synchronized 1-bit level
module sync_debounce #(
  parameter int unsigned CYCLES      = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
  logic diff, done;
  always_comb begin
    diff   = din ^ dout_q;
    done   = diff & tick & (cnt_q == LAST);
    cnt_d  = !diff ? '0 : !tick ? cnt_q : done ? '0 : cnt_q + 1'b1;
    dout_d = done ? din : dout_q;
    rise_d = done & din;
    fall_d = done & ~din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dout_q <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule
